// File: rtl/disp_scheduler.sv
// Display time-share scheduler: rotates speed/distance, alarm preempts.
// Optional alarm blink is enabled by defining DISP_BLINK_EN.
module disp_scheduler #(
    parameter int DWELL_TICKS = 16000,
    parameter int BLINK_TICKS = 4000,
    parameter int MAXV        = 9999
) (
    input  logic        clk_16k,
    input  logic        rst_n,
    input  logic [13:0] spd_val,
    input  logic        spd_vld,
    input  logic [13:0] dst_val,
    input  logic        dst_vld,
    input  logic [13:0] alm_code,
    input  logic        alm_req,
    output logic        alm_ack,
    output logic [13:0] disp_val,
    output logic [1:0]  disp_src,
    output logic        disp_blank,
    output logic        disp_chg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SPD  = 2'd1,
        DST  = 2'd2,
        ALM  = 2'd3
    } st_t;

    localparam int DW = $clog2(DWELL_TICKS);
    localparam logic [DW-1:0] DLAST = DW'(DWELL_TICKS - 1);
    localparam logic [13:0] VMAX = 14'(MAXV);

    st_t st, st_nx, ret_st, ret_nx;
    logic [DW-1:0] dcnt, dcnt_nx;
    logic [13:0] spd_sh, dst_sh, alm_sh;
    logic [13:0] spd_nx, dst_nx, alm_nx;
    logic have_spd, have_dst, alm_r;
    logic [13:0] val_nx;
    logic blank_nx, ack_nx, chg_nx;

    function automatic logic [13:0] sat(input logic [13:0] v);
        return (v > VMAX) ? VMAX : v;
    endfunction

`ifdef DISP_BLINK_EN
    localparam int BW = $clog2(BLINK_TICKS);
    localparam logic [BW-1:0] BLAST = BW'(BLINK_TICKS - 1);
    logic [BW-1:0] bcnt, bcnt_nx;

    // Counter restarts on each ALM entry; wraps at every blink toggle.
    always_comb begin
        bcnt_nx = '0;
        if (st_nx == ALM && st == ALM && bcnt != BLAST)
            bcnt_nx = bcnt + BW'(1);
    end

    always_ff @(posedge clk_16k) begin
        if (!rst_n) bcnt <= '0;
        else        bcnt <= bcnt_nx;
    end
`endif

    always_comb begin
        spd_nx  = spd_vld ? spd_val : spd_sh;
        dst_nx  = dst_vld ? dst_val : dst_sh;
        alm_nx  = alm_req ? alm_code : alm_sh;
        st_nx   = st;
        ret_nx  = ret_st;
        dcnt_nx = dcnt;
        if (alm_r) begin
            st_nx   = ALM;
            dcnt_nx = '0;
            if (st != ALM) ret_nx = st;
        end else begin
            unique case (st)
                IDLE: begin
                    dcnt_nx = '0;
                    if (have_spd)      st_nx = SPD;
                    else if (have_dst) st_nx = DST;
                end
                SPD: begin
                    if (dcnt == DLAST) begin
                        dcnt_nx = '0;
                        if (have_dst) st_nx = DST;
                    end else begin
                        dcnt_nx = dcnt + DW'(1);
                    end
                end
                DST: begin
                    if (dcnt == DLAST) begin
                        dcnt_nx = '0;
                        if (have_spd) st_nx = SPD;
                    end else begin
                        dcnt_nx = dcnt + DW'(1);
                    end
                end
                ALM: begin
                    st_nx   = ret_st;
                    dcnt_nx = '0;
                end
            endcase
        end

        val_nx   = '0;
        blank_nx = 1'b0;
        unique case (st_nx)
            IDLE: blank_nx = 1'b1;
            SPD:  val_nx = sat(spd_nx);
            DST:  val_nx = sat(dst_nx);
            ALM: begin
                val_nx = sat(alm_nx);
`ifdef DISP_BLINK_EN
                if (st == ALM && bcnt == BLAST) blank_nx = ~disp_blank;
                else if (st == ALM)             blank_nx = disp_blank;
`endif
            end
        endcase
        ack_nx = (st_nx == ALM) && (st != ALM);
        chg_nx = (st_nx != st);
    end

    always_ff @(posedge clk_16k) begin
        if (!rst_n) begin
            st         <= IDLE;
            ret_st     <= IDLE;
            dcnt       <= '0;
            spd_sh     <= '0;
            dst_sh     <= '0;
            alm_sh     <= '0;
            have_spd   <= 1'b0;
            have_dst   <= 1'b0;
            alm_r      <= 1'b0;
            disp_val   <= '0;
            disp_blank <= 1'b1;
            alm_ack    <= 1'b0;
            disp_chg   <= 1'b0;
        end else begin
            st         <= st_nx;
            ret_st     <= ret_nx;
            dcnt       <= dcnt_nx;
            spd_sh     <= spd_nx;
            dst_sh     <= dst_nx;
            alm_sh     <= alm_nx;
            have_spd   <= have_spd | spd_vld;
            have_dst   <= have_dst | dst_vld;
            alm_r      <= alm_req;
            disp_val   <= val_nx;
            disp_blank <= blank_nx;
            alm_ack    <= ack_nx;
            disp_chg   <= chg_nx;
        end
    end

    assign disp_src = st;

endmodule

// File: doc/disp_scheduler.md
# disp_scheduler

Time-shares the 4-digit seven-segment display between three value producers: vehicle speed, travelled distance and an alarm code. Normal operation rotates between speed and distance on a fixed dwell. An asserted alarm preempts the rotation until it is withdrawn. Sits between the measurement blocks and the digit scanner, and drives the scanner's value input at the scanner's 16 kHz scan clock.

## Interface
- DWELL_TICKS, 16000: cycles each rotating source stays on display (1 s at 16 kHz).
- BLINK_TICKS, 4000: alarm blink half-period in cycles (only used with DISP_BLINK_EN).
- MAXV, 9999: largest displayable value; larger inputs saturate to it.

Ports:
- clk_16k  in  1  display/scan clock; all logic on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- spd_val  in  14  speed value, sampled when spd_vld=1.
- spd_vld  in  1  one-cycle strobe, new speed value.
- dst_val  in  14  distance value, sampled when dst_vld=1.
- dst_vld  in  1  one-cycle strobe, new distance value.
- alm_code  in  14  alarm code, sampled every cycle while alm_req=1.
- alm_req  in  1  level alarm request.
- alm_ack  out  1  one-cycle pulse on the cycle ALM is entered.
- disp_val  out  14  value to scanner, always ≤ MAXV.
- disp_src  out  2  0 none, 1 speed, 2 distance, 3 alarm.
- disp_blank  out  1  scanner must blank all digits.
- disp_chg  out  1  one-cycle pulse whenever disp_src changes.

## Operation
- Shadow registers spd_sh and dst_sh load on their vld strobes. Flags have_spd and have_dst set on the first strobe after reset and never clear.
- States: IDLE, SPD, DST, ALM. Dwell counter dcnt counts 0..DWELL_TICKS-1.
- IDLE: go to SPD if have_spd, else to DST if have_dst, else stay in IDLE.
- SPD: when dcnt = DWELL_TICKS-1, go to DST if have_dst, else stay in SPD. In both cases dcnt restarts at 0.
- DST: same as SPD, with SPD as the target and have_spd as the condition.
- Any state to ALM when alm_req=1. ALM has priority over every other transition in that cycle.
  - On entry, the preempted state is saved in ret_st (IDLE if preempted from IDLE).
- ALM: while alm_req=1, stay in ALM. When alm_req=0, go to ret_st with dcnt=0, then re-evaluate IDLE rules normally.
- disp_val is the current source's data, saturated to MAXV:
  - SPD: spd_sh; DST: dst_sh; ALM: alm_code; IDLE: 0.
- If a vld strobe and a transition occur in the same cycle, the newly strobed value is used.
- disp_blank = 1 in IDLE, 0 in SPD and DST. ALM behaviour is set by Configuration.

## Timing
- Reset (rst_n=0 at an edge) returns these values after that edge:
  - state=IDLE, disp_val=0, disp_src=0, disp_blank=1, alm_ack=0, disp_chg=0.
  - have_* cleared, shadows 0, dcnt 0, blink counter 0.
- Reset mid-rotation or mid-alarm discards everything. It has priority over all inputs.
- All outputs are registered and update on the same edge as the state register.
- Input strobe or alm_req sampled at edge k is reflected on outputs after edge k+1's setup (one-cycle latency).
- Rotation: the source shown first after edge k changes after edge k+DWELL_TICKS.
- alm_ack and disp_chg are high for exactly one cycle. alm_ack fires once per ALM entry, even if alm_req stays high.
- alm_req high for one cycle gives one cycle in ALM, then return.
- Values above MAXV appear as MAXV. Values of 0 through MAXV pass unchanged.

## Configuration
- DISP_BLINK_EN defined:
  - In ALM, disp_blank starts at 0 on entry and toggles every BLINK_TICKS cycles.
  - The blink counter restarts on each ALM entry.
- DISP_BLINK_EN undefined:
  - disp_blank=0 throughout ALM.
  - No blink counter is instantiated.

## Test plan
- Reset, no strobes for 50000 cycles: disp_src=0, disp_blank=1, disp_val=0 throughout.
- spd_vld with spd_val=88, then dst_vld with dst_val=1234: disp_src=1 with disp_val=88, then switches to 2 with disp_val=1234 after 16000 cycles. disp_chg pulses at each switch.
- spd_val=12000: disp_val=9999 while in SPD.
- In DST with dcnt=5000, alm_req=1 for 100 cycles with alm_code=42: alm_ack single pulse, disp_src=3, disp_val=42. After release, returns to DST and the next switch occurs 16000 cycles after return.
- With DISP_BLINK_EN, alm_req held 20000 cycles: disp_blank toggles at cycles 4000, 8000, 12000 and 16000 after entry. Without the macro, disp_blank stays 0.
- rst_n=0 for one cycle while in ALM: all outputs return to reset values. With alm_req still high, ALM is re-entered and alm_ack pulses again.
